// File: rtl/fpu_share_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_share_arbiter_if                                                     |
// | Requester, core and result stb/ack links of the shared-FPU arbiter.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fpu_share_arbiter_if #(
    parameter int WIDTH_IN  = 32,
    parameter int WIDTH_OUT = 64
);
    logic [WIDTH_IN-1:0]  in0_a;
    logic                 in0_a_stb;
    logic                 in0_a_ack;
    logic [WIDTH_IN-1:0]  in1_a;
    logic                 in1_a_stb;
    logic                 in1_a_ack;
    logic [WIDTH_IN-1:0]  core_a;
    logic                 core_a_stb;
    logic                 core_a_ack;
    logic [WIDTH_OUT-1:0] core_z;
    logic                 core_z_stb;
    logic                 core_z_ack;
    logic [WIDTH_OUT-1:0] out0_z;
    logic                 out0_z_stb;
    logic                 out0_z_ack;
    logic [WIDTH_OUT-1:0] out1_z;
    logic                 out1_z_stb;
    logic                 out1_z_ack;

    // Arbiter side
    modport master (
        input  in0_a, in0_a_stb, in1_a, in1_a_stb,
        output in0_a_ack, in1_a_ack,
        output core_a, core_a_stb,
        input  core_a_ack,
        input  core_z, core_z_stb,
        output core_z_ack,
        output out0_z, out0_z_stb, out1_z, out1_z_stb,
        input  out0_z_ack, out1_z_ack
    );

    // Environment side: requesters, core and result sinks
    modport slave (
        output in0_a, in0_a_stb, in1_a, in1_a_stb,
        input  in0_a_ack, in1_a_ack,
        input  core_a, core_a_stb,
        output core_a_ack,
        output core_z, core_z_stb,
        input  core_z_ack,
        input  out0_z, out0_z_stb, out1_z, out1_z_stb,
        output out0_z_ack, out1_z_ack
    );
endinterface
`default_nettype wire

// File: rtl/fpu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_share_arbiter                                                        |
// | Round-robin sharing of one single-operand FPU core between two streams.  |
// | Optional core timeout enabled by defining ARB_TIMEOUT_EN.                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fpu_share_arbiter #(
    parameter int WIDTH_IN  = 32,
    parameter int WIDTH_OUT = 64,
    parameter int TIMEOUT   = 255
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fpu_share_arbiter_if.master  bus,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_PUT_A = 3'd2,
        S_GET_Z = 3'd3,
        S_PUT_Z = 3'd4
    } state_t;

    generate
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("TIMEOUT must be at least 1");
        end
    endgenerate

    state_t               r_state;
    logic                 r_grant;
    logic                 r_last_grant;
    logic                 r_in0_ack;
    logic                 r_in1_ack;
    logic [WIDTH_IN-1:0]  r_core_a;
    logic                 r_core_a_stb;
    logic                 r_core_z_ack;
    logic [WIDTH_OUT-1:0] r_out0_z;
    logic                 r_out0_stb;
    logic [WIDTH_OUT-1:0] r_out1_z;
    logic                 r_out1_stb;

    logic                 w_next_grant;
    logic                 w_sel_stb;
    logic                 w_sel_ack;
    logic [WIDTH_IN-1:0]  w_sel_a;
    logic                 w_out_stb;
    logic                 w_out_ack;

    // On a tie the requester that was not served last wins
    always_comb begin
        w_next_grant = bus.in1_a_stb;
        if (bus.in0_a_stb && bus.in1_a_stb) begin
            w_next_grant = ~r_last_grant;
        end
        w_sel_stb = r_grant ? bus.in1_a_stb  : bus.in0_a_stb;
        w_sel_ack = r_grant ? r_in1_ack      : r_in0_ack;
        w_sel_a   = r_grant ? bus.in1_a      : bus.in0_a;
        w_out_stb = r_grant ? r_out1_stb     : r_out0_stb;
        w_out_ack = r_grant ? bus.out1_z_ack : bus.out0_z_ack;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(TIMEOUT + 1);

    logic [C_CNT_W-1:0] r_tmo_cnt;
    logic               r_timeout_err;
    logic               w_tmo_hit;

    assign w_tmo_hit   = (r_tmo_cnt == C_CNT_W'(TIMEOUT - 1));
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_in0_ack    <= 1'b0;
            r_in1_ack    <= 1'b0;
            r_core_a     <= '0;
            r_core_a_stb <= 1'b0;
            r_core_z_ack <= 1'b0;
            r_out0_z     <= '0;
            r_out0_stb   <= 1'b0;
            r_out1_z     <= '0;
            r_out1_stb   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in0_a_stb || bus.in1_a_stb) begin
                        r_grant <= w_next_grant;
                        if (w_next_grant) begin
                            r_in1_ack <= 1'b1;
                        end else begin
                            r_in0_ack <= 1'b1;
                        end
                        r_state <= S_GET_A;
                    end
                end
                S_GET_A: begin
                    if (w_sel_stb && w_sel_ack) begin
                        r_in0_ack    <= 1'b0;
                        r_in1_ack    <= 1'b0;
                        r_core_a     <= w_sel_a;
                        r_core_a_stb <= 1'b1;
                        r_state      <= S_PUT_A;
                    end
                end
                S_PUT_A: begin
                    if (r_core_a_stb && bus.core_a_ack) begin
                        r_core_a_stb <= 1'b0;
                        r_core_z_ack <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        r_tmo_cnt    <= '0;
`endif
                        r_state      <= S_GET_Z;
                    end
                end
                S_GET_Z: begin
                    if (bus.core_z_stb && r_core_z_ack) begin
                        r_core_z_ack <= 1'b0;
                        if (r_grant) begin
                            r_out1_z   <= bus.core_z;
                            r_out1_stb <= 1'b1;
                        end else begin
                            r_out0_z   <= bus.core_z;
                            r_out0_stb <= 1'b1;
                        end
                        r_state <= S_PUT_Z;
                    end
`ifdef ARB_TIMEOUT_EN
                    // Silent core: return an all-ones result so the requester is released
                    else if (w_tmo_hit) begin
                        r_core_z_ack  <= 1'b0;
                        r_timeout_err <= 1'b1;
                        if (r_grant) begin
                            r_out1_z   <= '1;
                            r_out1_stb <= 1'b1;
                        end else begin
                            r_out0_z   <= '1;
                            r_out0_stb <= 1'b1;
                        end
                        r_state <= S_PUT_Z;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + C_CNT_W'(1);
                    end
`endif
                end
                S_PUT_Z: begin
                    if (w_out_stb && w_out_ack) begin
                        r_out0_stb   <= 1'b0;
                        r_out1_stb   <= 1'b0;
                        r_last_grant <= r_grant;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in0_a_ack  = r_in0_ack;
    assign bus.in1_a_ack  = r_in1_ack;
    assign bus.core_a     = r_core_a;
    assign bus.core_a_stb = r_core_a_stb;
    assign bus.core_z_ack = r_core_z_ack;
    assign bus.out0_z     = r_out0_z;
    assign bus.out0_z_stb = r_out0_stb;
    assign bus.out1_z     = r_out1_z;
    assign bus.out1_z_stb = r_out1_stb;
    assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fpu_share_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fpu_share_arbiter                                                     |
// | Scoreboarded bench: random requesters, modelled core and result sinks.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fpu_share_arbiter;
    localparam int WI  = 32;
    localparam int WO  = 64;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic timeout_err;

    always #5 clk = ~clk;

    fpu_share_arbiter_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) intf ();

    fpu_share_arbiter #(.WIDTH_IN(WI), .WIDTH_OUT(WO), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (intf),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Control knobs written only by the main sequence
    int          target0 = 0, target1 = 0, gap_max = 0;
    int          core_lat_lo = 0, core_lat_hi = 0;
    bit          core_silent = 0, core_fast = 1, sink_fast = 1;
    bit          stall0 = 0, stall1 = 0, fix_en = 0, tmo_push = 0;
    logic [31:0] fix0 = '0, fix1 = '0;

    int          issued0 = 0, issued1 = 0;
    logic [WO-1:0] exp_q0[$];
    logic [WO-1:0] exp_q1[$];
    int          served_q[$];
    int          exp_served[$];
    bit          m_lg = 1'b1;

    // Transfer flags sampled on the falling edge: a set flag means the
    // handshake completes on the following rising edge
    bit          xa0, xa1, xca, xcz, xo0, xo1;
    logic [WI-1:0] ca_val;

    // Behavioural float-to-double conversion (normals, zero, inf/nan; denormals flush)
    function automatic logic [63:0] f2d(input logic [31:0] a);
        logic [10:0] e;
        if (a[30:23] == 8'd0)        return {a[31], 63'd0};
        else if (a[30:23] == 8'hFF)  return {a[31], 11'h7FF, a[22:0], 29'd0};
        e = 11'(a[30:23]) + 11'd896;
        return {a[31], e, a[22:0], 29'd0};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Round-robin reference: both pending -> the one not served last goes first
    task automatic model_serve(input bit p0, input bit p1);
        if (p0 && p1) begin
            exp_served.push_back(m_lg ? 0 : 1);
            exp_served.push_back(m_lg ? 1 : 0);
        end else if (p0) begin
            exp_served.push_back(0);
            m_lg = 1'b0;
        end else if (p1) begin
            exp_served.push_back(1);
            m_lg = 1'b1;
        end
    endtask

    task automatic check_order(input string name);
        check({name, "_count"}, 128'(served_q.size()), 128'(exp_served.size()));
        for (int i = 0; i < exp_served.size() && i < served_q.size(); i++)
            check(name, 128'(served_q[i]), 128'(exp_served[i]));
        served_q.delete();
        exp_served.delete();
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (!(issued0 == target0 && issued1 == target1 && !intf.in0_a_stb &&
                 !intf.in1_a_stb && exp_q0.size() == 0 && exp_q1.size() == 0 && !busy)
               && n < bound) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic wait_sig(input string name, input int which, input int bound);
        int n = 0;
        while (n < bound && !((which == 0 && intf.out0_z_stb) || (which == 1 && intf.core_z_ack)
                              || (which == 2 && intf.in0_a_stb))) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL %s: event %0d not seen in %0d cycles", name, which, bound);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_q0.delete();
        exp_q1.delete();
        served_q.delete();
        exp_served.delete();
        m_lg = 1'b1;
        rst  = 1'b0;
    endtask

    // Requester driver: issues operands up to target counts with random gaps
    initial begin : driver
        int gap0 = 0, gap1 = 0;
        logic [31:0] a;
        intf.in0_a = '0; intf.in0_a_stb = 1'b0;
        intf.in1_a = '0; intf.in1_a_stb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                intf.in0_a_stb = 1'b0;
                intf.in1_a_stb = 1'b0;
                gap0 = 0;
                gap1 = 0;
            end else begin
                if (intf.in0_a_stb) begin
                    if (xa0) begin intf.in0_a_stb = 1'b0; gap0 = $urandom_range(gap_max, 0); end
                end else if (gap0 > 0) gap0--;
                else if (issued0 < target0) begin
                    a = fix_en ? fix0 : $urandom;
                    intf.in0_a = a; intf.in0_a_stb = 1'b1; issued0++;
                    exp_q0.push_back(tmo_push ? {WO{1'b1}} : f2d(a));
                end
                if (intf.in1_a_stb) begin
                    if (xa1) begin intf.in1_a_stb = 1'b0; gap1 = $urandom_range(gap_max, 0); end
                end else if (gap1 > 0) gap1--;
                else if (issued1 < target1) begin
                    a = fix_en ? fix1 : $urandom;
                    intf.in1_a = a; intf.in1_a_stb = 1'b1; issued1++;
                    exp_q1.push_back(tmo_push ? {WO{1'b1}} : f2d(a));
                end
            end
        end
    end

    // Shared core model
    initial begin : core
        bit have = 0;
        int d = 0;
        logic [WI-1:0] op = '0;
        intf.core_a_ack = 1'b0; intf.core_z = '0; intf.core_z_stb = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                have = 0; intf.core_z_stb = 1'b0; intf.core_a_ack = 1'b0;
            end else begin
                if (xcz) begin intf.core_z_stb = 1'b0; have = 0; end
                if (xca) begin have = !core_silent; op = ca_val; d = $urandom_range(core_lat_hi, core_lat_lo); end
                if (have && !intf.core_z_stb) begin
                    if (d > 0) d--;
                    else begin intf.core_z = f2d(op); intf.core_z_stb = 1'b1; end
                end
                intf.core_a_ack = core_fast || ($urandom_range(3, 0) != 0);
            end
        end
    end

    // Result sinks
    initial begin : sinks
        intf.out0_z_ack = 1'b0; intf.out1_z_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            intf.out0_z_ack = !stall0 && (sink_fast || ($urandom_range(2, 0) != 0));
            intf.out1_z_ack = !stall1 && (sink_fast || ($urandom_range(2, 0) != 0));
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        bit p_stb0 = 0, p_stb1 = 0, p_xa0 = 0, p_xa1 = 0;
        logic [WO-1:0] p_z0 = '0, p_z1 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                xa0 = 0; xa1 = 0; xca = 0; xcz = 0; xo0 = 0; xo1 = 0;
                p_stb0 = 0; p_stb1 = 0; p_xa0 = 0; p_xa1 = 0;
            end else begin
                xa0 = intf.in0_a_stb && intf.in0_a_ack;
                xa1 = intf.in1_a_stb && intf.in1_a_ack;
                xca = intf.core_a_stb && intf.core_a_ack;
                xcz = intf.core_z_stb && intf.core_z_ack;
                xo0 = intf.out0_z_stb && intf.out0_z_ack;
                xo1 = intf.out1_z_stb && intf.out1_z_ack;
                ca_val = intf.core_a;
                if (xa0) served_q.push_back(0);
                if (xa1) served_q.push_back(1);
                if (xo0) begin
                    if (exp_q0.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out0_unexpected: got %0h required no result", intf.out0_z);
                    end else check("out0_z", 128'(intf.out0_z), 128'(exp_q0.pop_front()));
                end
                if (xo1) begin
                    if (exp_q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL out1_unexpected: got %0h required no result", intf.out1_z);
                    end else check("out1_z", 128'(intf.out1_z), 128'(exp_q1.pop_front()));
                end
                if (intf.in0_a_ack || intf.in1_a_ack)
                    check("ack_exclusive", 128'({intf.in0_a_ack, intf.in1_a_ack} == 2'b11), 128'(0));
                if (intf.out0_z_stb || intf.out1_z_stb)
                    check("out_stb_exclusive", 128'({intf.out0_z_stb, intf.out1_z_stb} == 2'b11), 128'(0));
                if (p_xa0) check("in0_ack_pulse", 128'(intf.in0_a_ack), 128'(0));
                if (p_xa1) check("in1_ack_pulse", 128'(intf.in1_a_ack), 128'(0));
                if (p_stb0) check("out0_hold", {63'd0, intf.out0_z_stb, intf.out0_z}, {63'd0, 1'b1, p_z0});
                if (p_stb1) check("out1_hold", {63'd0, intf.out1_z_stb, intf.out1_z}, {63'd0, 1'b1, p_z1});
                p_stb0 = intf.out0_z_stb && !xo0; p_z0 = intf.out0_z; p_xa0 = xa0;
                p_stb1 = intf.out1_z_stb && !xo1; p_z1 = intf.out1_z; p_xa1 = xa1;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int bad_busy, bad_tmo;
        repeat (3) @(negedge clk);
        // Reset state (rst still high, several edges seen)
        check("rst_in0_ack",  128'(intf.in0_a_ack), 0);
        check("rst_in1_ack",  128'(intf.in1_a_ack), 0);
        check("rst_core_stb", 128'(intf.core_a_stb), 0);
        check("rst_core_ack", 128'(intf.core_z_ack), 0);
        check("rst_out0_stb", 128'(intf.out0_z_stb), 0);
        check("rst_out1_stb", 128'(intf.out1_z_stb), 0);
        check("rst_busy",     128'(busy), 0);
        check("rst_tmo_err",  128'(timeout_err), 0);
        check("rst_core_a",   128'(intf.core_a), 0);
        check("rst_out0_z",   128'(intf.out0_z), 0);
        check("rst_out1_z",   128'(intf.out1_z), 0);
        rst = 1'b0;

        // Single request, 3-cycle core
        core_lat_lo = 3; core_lat_hi = 3; fix_en = 1; fix0 = 32'h3F800000; fix1 = 32'h40000000;
        target0++;
        n = 0;
        while (n < 60 && !(intf.out0_z_stb && intf.out0_z_ack)) begin @(negedge clk); n++; end
        check("single_out0_z", 128'(intf.out0_z), 128'(64'h3FF0000000000000));
        @(negedge clk);
        check("single_busy_fall", 128'(busy), 0);
        wait_idle("single_idle", 50);

        // Zero-wait latency, requester stb to result stb
        core_lat_lo = 0; core_lat_hi = 0;
        target0++;
        wait_sig("lat_stb", 2, 20);
        n = 0;
        while (n < 30 && !intf.out0_z_stb) begin @(negedge clk); n++; end
        check("latency", 128'(n), 128'(4));
        wait_idle("lat_idle", 50);

        // Tie arbitration after reset
        do_reset();
        fix0 = 32'h40000000; fix1 = 32'hC0000000;
        target0++; target1++; model_serve(1, 1); wait_idle("tie1", 100);
        target0++; target1++; model_serve(1, 1); wait_idle("tie2", 100);
        target0++;            model_serve(1, 0); wait_idle("lone0", 100);
        target0++; target1++; model_serve(1, 1); wait_idle("tie3", 100);
        check_order("rr_order");

        // Backpressure on out0 blocks in1
        stall0 = 1;
        target0++; model_serve(1, 0);
        wait_sig("bp_out0", 0, 40);
        target1++; model_serve(0, 1);
        repeat (10) begin
            @(negedge clk);
            check("bp_out0_stb", 128'(intf.out0_z_stb), 1);
            check("bp_in1_ack",  128'(intf.in1_a_ack), 0);
        end
        stall0 = 0;
        wait_idle("bp_idle", 100);
        check_order("bp_order");

        // Reset while waiting for the core result
        core_silent = 1;
        target1++;
        wait_sig("rz_getz", 1, 40);
        rst = 1'b1;
        @(negedge clk);
        check("rz_core_ack", 128'(intf.core_z_ack), 0);
        check("rz_core_stb", 128'(intf.core_a_stb), 0);
        check("rz_acks",     128'({intf.in0_a_ack, intf.in1_a_ack}), 0);
        check("rz_out_stbs", 128'({intf.out0_z_stb, intf.out1_z_stb}), 0);
        check("rz_busy",     128'(busy), 0);
        do_reset();
        core_silent = 0; fix1 = 32'hBF800000;
        target1++;
        wait_idle("rz_recover", 100);

        // Random traffic
        fix_en = 0; gap_max = 4; core_fast = 0; sink_fast = 0;
        core_lat_lo = 0; core_lat_hi = 5;
        target0 += 40; target1 += 40;
        wait_idle("random", 10000);
        served_q.delete();

`ifdef ARB_TIMEOUT_EN
        core_silent = 1; tmo_push = 1; core_fast = 1; sink_fast = 1;
        target0++;
        @(negedge clk);
        @(negedge clk);
        tmo_push = 0;
        wait_sig("tmo_getz", 1, 40);
        n = 0;
        while (n < 40 && !intf.out0_z_stb) begin @(negedge clk); n++; end
        check("tmo_cycles", 128'(n), 128'(TMO));
        check("tmo_err_set", 128'(timeout_err), 1);
        wait_idle("tmo_idle", 50);
        core_silent = 0;
        target1++;
        wait_idle("tmo_good", 100);
        check("tmo_err_sticky", 128'(timeout_err), 1);
        do_reset();
        @(negedge clk);
        check("tmo_err_clear", 128'(timeout_err), 0);
`else
        core_silent = 1; core_fast = 1; sink_fast = 1;
        target0++;
        wait_sig("hang_getz", 1, 40);
        bad_busy = 0; bad_tmo = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!busy) bad_busy++;
            if (timeout_err) bad_tmo++;
        end
        check("hang_busy", 128'(bad_busy), 0);
        check("hang_tmo_err", 128'(bad_tmo), 0);
        check("hang_no_out", 128'(intf.out0_z_stb), 0);
        do_reset();
        core_silent = 0;
`endif

        check("exp_q0_empty", 128'(exp_q0.size()), 0);
        check("exp_q1_empty", 128'(exp_q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
